instr_sequencer: RTL and testbench

- Host-side instruction issuer for the 8-bit compute unit.
- Buffers a short program of 16-bit instructions, loaded byte-wise from a host port.
- On command, issues one instruction per enabled cycle to the compute unit, with `instr_valid` driving the unit's `ena`.
- Captures each 8-bit result one cycle after execution, keeping the last result and a running XOR checksum.

---
 rtl/instr_sequencer_if.sv | 57 +++++
 rtl/instr_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Groups the host command port, the compute-unit issue/result port and the
//   status outputs of instr_sequencer into one bundle.
//
//   Handshake: there is no ready signal anywhere on this bus. instr_valid is a
//   one-way strobe that drives the compute unit's enable; every enabled cycle
//   with instr_valid=1 is exactly one executed instruction. result_in is
//   expected one cycle after its instruction was executed. cmd is a one-cycle
//   request sampled on every enabled edge; the host holds it while ena is low.
//
//   Signals (direction as seen from the sequencer, modport slave):
//     cmd          in   2     00 none, 01 write byte, 10 start, 11 clear/abort
//     wr_data      in   8     write byte; bit0 = loop request on start
//     result_in    in   8     compute unit result byte
//     instr_out    out  16    issued instruction (registered)
//     instr_valid  out  1     instruction valid / compute unit enable
//     busy         out  1     sequencer is running or draining
//     done         out  1     run finished
//     overflow     out  1     sticky: write attempted with buffer full
//     prog_len     out  AW+1  committed instruction count
//     result_last  out  8     most recent captured result
//     result_xor   out  8     XOR of results captured in this run
//     dbg_state    out  2     FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//     dbg_cap_pend out  1     a result is due for capture on the next edge
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int AW = 4
);
  logic [1:0]  cmd;
  logic [7:0]  wr_data;
  logic [7:0]  result_in;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [AW:0] prog_len;
  logic [7:0]  result_last;
  logic [7:0]  result_xor;
  logic [1:0]  dbg_state;
  logic        dbg_cap_pend;

  // Host / compute-unit side.
  modport master (
    output cmd, wr_data, result_in,
    input  instr_out, instr_valid, busy, done, overflow, prog_len,
    input  result_last, result_xor, dbg_state, dbg_cap_pend
  );

  // Sequencer side.
  modport slave (
    input  cmd, wr_data, result_in,
    output instr_out, instr_valid, busy, done, overflow, prog_len,
    output result_last, result_xor, dbg_state, dbg_cap_pend
  );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Host-side instruction issuer for the 8-bit compute unit. A host loads a
//   short program of 16-bit instructions one byte at a time (high byte first),
//   then issues a start. The sequencer streams one instruction per enabled
//   cycle to the compute unit and captures each result one cycle after it was
//   executed, keeping the last result and a running XOR checksum.
//
//   Optional feature (macro SEQ_LOOP_EN): a start with wr_data[0]=1 on a
//   non-empty program arms loop mode, where the program is reissued forever
//   without a bubble until a clear/abort command arrives. Without the macro
//   wr_data is ignored on start.
//
//   Ports:
//     clk    in   clock, all logic on the rising edge
//     rst_n  in   synchronous active-low reset
//     ena    in   global enable; low freezes every register
//     bus    slave modport of instr_sequencer_if (commands, issue, results,
//            status and debug state)
//
//   Parameters:
//     DEPTH  program buffer entries (power of two, 2..256)
//     AW     log2(DEPTH)
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  instr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  CMD_WRITE = 2'b01;
  localparam logic [1:0]  CMD_START = 2'b10;
  localparam logic [1:0]  CMD_CLEAR = 2'b11;
  localparam logic [AW:0] W_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] W_ONE     = (AW+1)'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_mem [DEPTH];
  logic [7:0]  r_hi;           // latched high byte of a half-written instr
  logic        r_pend;         // high byte latched, low byte outstanding
  logic [AW:0] r_prog_len;
  logic [AW:0] r_rd_ptr;
  logic [15:0] r_instr_out;
  logic        r_instr_valid;
  logic        r_cap_pend;     // instr_valid delayed one edge: result due now
  logic        r_overflow;
  logic [7:0]  r_result_last;
  logic [7:0]  r_result_xor;
`ifdef SEQ_LOOP_EN
  logic        r_loop;
`endif

  // -------------------------------------------------------------------------
  // Next-state values
  // -------------------------------------------------------------------------
  state_t      w_state_nxt;
  logic [7:0]  w_hi_nxt;
  logic        w_pend_nxt;
  logic [AW:0] w_prog_len_nxt;
  logic [AW:0] w_rd_ptr_nxt;
  logic [15:0] w_instr_out_nxt;
  logic        w_instr_valid_nxt;
  logic        w_cap_pend_nxt;
  logic        w_overflow_nxt;
  logic [7:0]  w_result_last_nxt;
  logic [7:0]  w_result_xor_nxt;
  logic        w_mem_we;
  logic [15:0] w_mem_wdata;
  logic [15:0] w_rd_data;
`ifdef SEQ_LOOP_EN
  logic        w_loop_nxt;
`endif

  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_state_nxt       = r_state;
    w_hi_nxt          = r_hi;
    w_pend_nxt        = r_pend;
    w_prog_len_nxt    = r_prog_len;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_instr_out_nxt   = r_instr_out;
    w_instr_valid_nxt = r_instr_valid;
    w_cap_pend_nxt    = r_instr_valid;
    w_overflow_nxt    = r_overflow;
    w_result_last_nxt = r_result_last;
    w_result_xor_nxt  = r_result_xor;
    w_mem_we          = 1'b0;
    w_mem_wdata       = {r_hi, bus.wr_data};
`ifdef SEQ_LOOP_EN
    w_loop_nxt        = r_loop;
`endif

    // Result capture runs in every state, including the edge of an abort, so
    // the result already in flight at that edge is kept.
    if (r_cap_pend) begin
      w_result_last_nxt = bus.result_in;
      w_result_xor_nxt  = r_result_xor ^ bus.result_in;
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        case (bus.cmd)
          CMD_WRITE: begin
            w_state_nxt = S_IDLE;
            if (r_prog_len == W_DEPTH) begin
              // Buffer full: byte dropped, pending half left as it was.
              w_overflow_nxt = 1'b1;
            end else if (!r_pend) begin
              w_hi_nxt   = bus.wr_data;
              w_pend_nxt = 1'b1;
            end else begin
              w_mem_we       = 1'b1;
              w_prog_len_nxt = r_prog_len + W_ONE;
              w_pend_nxt     = 1'b0;
            end
          end
          CMD_START: begin
            w_pend_nxt       = 1'b0;
            w_result_xor_nxt = 8'h00;
            w_rd_ptr_nxt     = '0;
            w_state_nxt      = (r_prog_len == '0) ? S_DONE : S_RUN;
`ifdef SEQ_LOOP_EN
            w_loop_nxt       = bus.wr_data[0] && (r_prog_len != '0);
`endif
          end
          CMD_CLEAR: begin
            w_prog_len_nxt = '0;
            w_pend_nxt     = 1'b0;
            w_overflow_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end
          default: ;
        endcase
      end

      S_RUN: begin
        if (bus.cmd == CMD_CLEAR) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_out_nxt   = 16'h0000;
          w_cap_pend_nxt    = 1'b0;
          w_state_nxt       = S_IDLE;
`ifdef SEQ_LOOP_EN
          w_loop_nxt        = 1'b0;
`endif
        end else if (r_rd_ptr < r_prog_len) begin
          w_instr_out_nxt   = w_rd_data;
          w_instr_valid_nxt = 1'b1;
          w_rd_ptr_nxt      = r_rd_ptr + W_ONE;
        end else begin
`ifdef SEQ_LOOP_EN
          if (r_loop) begin
            // Wrap and issue entry 0 on this same edge: no bubble.
            w_instr_out_nxt   = r_mem[{AW{1'b0}}];
            w_instr_valid_nxt = 1'b1;
            w_rd_ptr_nxt      = W_ONE;
          end else begin
            w_instr_out_nxt   = 16'h0000;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_DRAIN;
          end
`else
          w_instr_out_nxt   = 16'h0000;
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_DRAIN;
`endif
        end
      end

      S_DRAIN: begin
        if (bus.cmd == CMD_CLEAR) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_out_nxt   = 16'h0000;
          w_cap_pend_nxt    = 1'b0;
          w_state_nxt       = S_IDLE;
        end else if (r_cap_pend && !r_instr_valid) begin
          // Final result is captured on this edge by the logic above.
          w_state_nxt = S_DONE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hi          <= 8'h00;
      r_pend        <= 1'b0;
      r_prog_len    <= '0;
      r_rd_ptr      <= '0;
      r_instr_out   <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_cap_pend    <= 1'b0;
      r_overflow    <= 1'b0;
      r_result_last <= 8'h00;
      r_result_xor  <= 8'h00;
`ifdef SEQ_LOOP_EN
      r_loop        <= 1'b0;
`endif
    end else if (ena) begin
      r_state       <= w_state_nxt;
      r_hi          <= w_hi_nxt;
      r_pend        <= w_pend_nxt;
      r_prog_len    <= w_prog_len_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_instr_out   <= w_instr_out_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_cap_pend    <= w_cap_pend_nxt;
      r_overflow    <= w_overflow_nxt;
      r_result_last <= w_result_last_nxt;
      r_result_xor  <= w_result_xor_nxt;
`ifdef SEQ_LOOP_EN
      r_loop        <= w_loop_nxt;
`endif
    end
  end

  // Program buffer: no reset, contents are only meaningful below prog_len.
  always_ff @(posedge clk) begin
    if (rst_n && ena && w_mem_we) begin
      r_mem[r_prog_len[AW-1:0]] <= w_mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.instr_out    = r_instr_out;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done         = (r_state == S_DONE);
  assign bus.overflow     = r_overflow;
  assign bus.prog_len     = r_prog_len;
  assign bus.result_last  = r_result_last;
  assign bus.result_xor   = r_result_xor;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_cap_pend = r_cap_pend;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed bench for instr_sequencer. A small compute-unit model answers
//   each executed instruction one cycle later; issued instructions are checked
//   in order against an expected queue filled when a run is started.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

`ifdef SEQ_LOOP_EN
  localparam logic [7:0] START_D = 8'h00;
`else
  // Loop request bit set: must be ignored when the feature is absent.
  localparam logic [7:0] START_D = 8'h01;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int          checks    = 0;
  int          errors    = 0;
  int          issue_cnt = 0;
  logic [15:0] exp_q[$];
  logic        edge_en   = 1'b0;
  logic [7:0]  cu_q      = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Compute-unit model: known answers for the reference program, a simple
  // byte XOR for everything else.
  function automatic logic [7:0] cu_f(input logic [15:0] i);
    case (i)
      16'h1105: return 8'h05;
      16'h1203: return 8'h03;
      16'h2312: return 8'h08;
      default:  return i[15:8] ^ i[7:0];
    endcase
  endfunction

  // Compute unit executes on its enable (instr_valid) and answers next cycle.
  always @(posedge clk) begin
    edge_en = ena && rst_n;
    if (ena && bus.instr_valid) cu_q <= cu_f(bus.instr_out);
  end
  assign bus.result_in = cu_q;

  // ---------------- scoreboard: issued instructions ----------------
  always @(negedge clk) begin
    if (edge_en && bus.instr_valid) begin
      issue_cnt++;
      chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("instr_out", 32'(bus.instr_out), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d);
    bus.cmd     = c;
    bus.wr_data = d;
    tick();
    bus.cmd     = 2'b00;
    bus.wr_data = 8'h00;
  endtask

  task automatic write_instr(input logic [15:0] w);
    do_cmd(2'b01, w[15:8]);
    do_cmd(2'b01, w[7:0]);
  endtask

  task automatic load3();
    do_cmd(2'b11, 8'h00);
    write_instr(16'h1105);
    write_instr(16'h1203);
    write_instr(16'h2312);
  endtask

  task automatic push3();
    exp_q.push_back(16'h1105);
    exp_q.push_back(16'h1203);
    exp_q.push_back(16'h2312);
  endtask

  task automatic run_wait(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] fill [DEPTH];
  logic [7:0]  exp_xor;
  int          n;
  int          n_iss;

  initial begin
    bus.cmd     = 2'b00;
    bus.wr_data = 8'h00;
    rst_n       = 1'b0;
    ena         = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_state",       32'(bus.dbg_state),    32'd0);
    chk("rst_instr_out",   32'(bus.instr_out),    32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid),  32'd0);
    chk("rst_busy",        32'(bus.busy),         32'd0);
    chk("rst_done",        32'(bus.done),         32'd0);
    chk("rst_overflow",    32'(bus.overflow),     32'd0);
    chk("rst_prog_len",    32'(bus.prog_len),     32'd0);
    chk("rst_result_last", 32'(bus.result_last),  32'h0);
    chk("rst_result_xor",  32'(bus.result_xor),   32'h0);
    chk("rst_cap_pend",    32'(bus.dbg_cap_pend), 32'd0);
    rst_n = 1'b1;

    // A start while ena is low is lost
    ena = 1'b0;
    do_cmd(2'b10, 8'h00);
    chk("stall_cmd_ignored", 32'(bus.dbg_state), 32'd0);
    ena = 1'b1;

    // Reference 3-instruction run
    load3();
    chk("t1_prog_len", 32'(bus.prog_len), 32'd3);
    push3();
    n_iss = issue_cnt;
    do_cmd(2'b10, START_D);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    run_wait(n);
    chk("t1_done_edges",  32'(n),               32'd5);
    chk("t1_issues",      32'(issue_cnt-n_iss), 32'd3);
    chk("t1_q_empty",     32'(exp_q.size()),    32'd0);
    chk("t1_result_last", 32'(bus.result_last), 32'h08);
    chk("t1_result_xor",  32'(bus.result_xor),  32'h0E);
    chk("t1_valid_low",   32'(bus.instr_valid), 32'd0);
    chk("t1_busy_low",    32'(bus.busy),        32'd0);

    // Empty program: straight to DONE
    do_cmd(2'b11, 8'h00);
    chk("t2_prog_len", 32'(bus.prog_len),  32'd0);
    chk("t2_state",    32'(bus.dbg_state), 32'd0);
    do_cmd(2'b10, 8'h00);
    chk("t2_done",        32'(bus.done),        32'd1);
    chk("t2_result_xor",  32'(bus.result_xor),  32'h00);
    chk("t2_result_last", 32'(bus.result_last), 32'h08);

    // Fill the buffer, then overflow it
    do_cmd(2'b11, 8'h00);
    exp_xor = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 16'($urandom_range(0, 16'hFFFF));
      write_instr(fill[i]);
      exp_q.push_back(fill[i]);
      exp_xor = exp_xor ^ cu_f(fill[i]);
    end
    chk("t3_full_len",  32'(bus.prog_len), 32'(DEPTH));
    chk("t3_no_ovf",    32'(bus.overflow), 32'd0);
    do_cmd(2'b01, 8'hA5);
    do_cmd(2'b01, 8'h5A);
    chk("t3_ovf_len",   32'(bus.prog_len), 32'(DEPTH));
    chk("t3_ovf",       32'(bus.overflow), 32'd1);
    do_cmd(2'b10, 8'h00);
    run_wait(n);
    chk("t3_done_edges",  32'(n),               32'(DEPTH + 2));
    chk("t3_q_empty",     32'(exp_q.size()),    32'd0);
    chk("t3_result_xor",  32'(bus.result_xor),  32'(exp_xor));
    chk("t3_result_last", 32'(bus.result_last), 32'(cu_f(fill[DEPTH-1])));
    do_cmd(2'b01, 8'h77);
    chk("t3_done_to_idle", 32'(bus.dbg_state), 32'd0);
    chk("t3_len_kept",     32'(bus.prog_len),  32'(DEPTH));
    chk("t3_ovf_sticky",   32'(bus.overflow),  32'd1);
    do_cmd(2'b11, 8'h00);
    chk("t3_clr_len", 32'(bus.prog_len), 32'd0);
    chk("t3_clr_ovf", 32'(bus.overflow), 32'd0);

    // Stall of two cycles after the second issue; a stray half-instruction
    // is discarded by the start
    load3();
    do_cmd(2'b01, 8'hAA);
    push3();
    do_cmd(2'b10, START_D);
    tick();
    tick();
    ena = 1'b0;
    tick();
    tick();
    chk("t4_frozen_instr",    32'(bus.instr_out),    32'h1203);
    chk("t4_frozen_valid",    32'(bus.instr_valid),  32'd1);
    chk("t4_frozen_cap_pend", 32'(bus.dbg_cap_pend), 32'd1);
    chk("t4_frozen_xor",      32'(bus.result_xor),   32'h00);
    ena = 1'b1;
    run_wait(n);
    chk("t4_done_edges",  32'(n),               32'd3);
    chk("t4_result_xor",  32'(bus.result_xor),  32'h0E);
    chk("t4_result_last", 32'(bus.result_last), 32'h08);
    chk("t4_q_empty",     32'(exp_q.size()),    32'd0);
    write_instr(16'h4455);
    chk("t4_len4", 32'(bus.prog_len), 32'd4);
    push3();
    exp_q.push_back(16'h4455);
    do_cmd(2'b10, 8'h00);
    run_wait(n);
    chk("t4b_done_edges",  32'(n),               32'd6);
    chk("t4b_result_xor",  32'(bus.result_xor),  32'h1F);
    chk("t4b_result_last", 32'(bus.result_last), 32'h11);
    chk("t4b_q_empty",     32'(exp_q.size()),    32'd0);

    // Abort one cycle after the second issue, then rerun
    load3();
    push3();
    do_cmd(2'b10, START_D);
    tick();
    tick();
    do_cmd(2'b11, 8'h00);
    chk("t5_valid",       32'(bus.instr_valid),  32'd0);
    chk("t5_instr_out",   32'(bus.instr_out),    32'h0);
    chk("t5_state",       32'(bus.dbg_state),    32'd0);
    chk("t5_prog_len",    32'(bus.prog_len),     32'd3);
    chk("t5_result_last", 32'(bus.result_last),  32'h05);
    chk("t5_result_xor",  32'(bus.result_xor),   32'h05);
    chk("t5_cap_pend",    32'(bus.dbg_cap_pend), 32'd0);
    chk("t5_q_left",      32'(exp_q.size()),     32'd1);
    exp_q.delete();
    tick();
    chk("t5_no_late_cap", 32'(bus.result_last), 32'h05);
    push3();
    do_cmd(2'b10, START_D);
    run_wait(n);
    chk("t5_done_edges",  32'(n),               32'd5);
    chk("t5_rerun_xor",   32'(bus.result_xor),  32'h0E);
    chk("t5_rerun_last",  32'(bus.result_last), 32'h08);

`ifdef SEQ_LOOP_EN
    // Loop mode: back-to-back passes until abort. The abort lands on the
    // edge that captures the sixth result, so two full passes cancel out.
    do_cmd(2'b11, 8'h00);
    load3();
    push3();
    push3();
    push3();
    n_iss = issue_cnt;
    do_cmd(2'b10, 8'h01);
    repeat (7) tick();
    chk("t6_issues",    32'(issue_cnt-n_iss), 32'd7);
    chk("t6_no_done",   32'(bus.done),        32'd0);
    chk("t6_busy",      32'(bus.busy),        32'd1);
    chk("t6_instr_out", 32'(bus.instr_out),   32'h1105);
    do_cmd(2'b11, 8'h00);
    chk("t6_result_xor", 32'(bus.result_xor),  32'h00);
    chk("t6_valid",      32'(bus.instr_valid), 32'd0);
    chk("t6_state",      32'(bus.dbg_state),   32'd0);
    chk("t6_q_left",     32'(exp_q.size()),    32'd2);
    exp_q.delete();
`endif

    // Reset in the middle of a run
    push3();
    do_cmd(2'b10, START_D);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t7_state",       32'(bus.dbg_state),   32'd0);
    chk("t7_valid",       32'(bus.instr_valid), 32'd0);
    chk("t7_instr_out",   32'(bus.instr_out),   32'h0);
    chk("t7_prog_len",    32'(bus.prog_len),    32'd0);
    chk("t7_result_last", 32'(bus.result_last), 32'h0);
    chk("t7_result_xor",  32'(bus.result_xor),  32'h0);
    chk("t7_q_left",      32'(exp_q.size()),    32'd2);
    exp_q.delete();
    rst_n = 1'b1;
    tick();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
